pixel_word_packer: RTL and testbench



---
 rtl/lightboard_pkg.sv | 12 +
 rtl/lane_accumulator.sv | 44 ++++
 rtl/pixel_word_packer.sv | 138 +++++++++++++
 tb/tb_pixel_word_packer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lightboard_pkg.sv
// lightboard_pkg: shared packer state type and default frame geometry
//   packer_state_t : IDLE (no start address held) / PACK (accumulating pixels)
//   FRAME_W, FRAME_H, FRAME_PIX : default 320x240 frame
package lightboard_pkg;

    typedef enum logic {IDLE, PACK} packer_state_t;

    localparam int FRAME_W   = 320;
    localparam int FRAME_H   = 240;
    localparam int FRAME_PIX = FRAME_W * FRAME_H;

endpackage

// File: rtl/lane_accumulator.sv
// lane_accumulator: PACK x PIX_W word register with per-lane written mask
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : drop the held word and mask
//   load       : write din into lane (after clr when both are set)
//   lane, din  : target lane and pixel data
//   data, mask : held word (unwritten lanes are 0) and written-lane mask
module lane_accumulator #(
    parameter int PIX_W = 8,
    parameter int PACK  = 4,
    parameter int LW    = (PACK > 1) ? $clog2(PACK) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  load,
    input  logic [LW-1:0]         lane,
    input  logic [PIX_W-1:0]      din,
    output logic [PIX_W*PACK-1:0] data,
    output logic [PACK-1:0]       mask
);

    logic [PIX_W*PACK-1:0] data_nx;
    logic [PACK-1:0]       mask_nx;

    always_comb begin
        data_nx = clr ? '0 : data;
        mask_nx = clr ? '0 : mask;
        if (load) begin
            data_nx[lane*PIX_W +: PIX_W] = din;
            mask_nx[lane]                = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            mask <= '0;
        end else begin
            data <= data_nx;
            mask <= mask_nx;
        end
    end

endmodule

// File: rtl/pixel_word_packer.sv
// pixel_word_packer: packs a start-addressed pixel stream into PACK-pixel frame-buffer BRAM writes
//   clk, rst_n               : clock, asynchronous active-low reset
//   addr_axiiv, addr_axiid   : start-address beat (pixel index)
//   pixel_axiiv, pixel_axiid : pixel stream, one per cycle, no backpressure
//   flush                    : commit a pending partial word
//   axiov, addr_axiod        : BRAM write enable, word address
//   pixel_axiod, lane_we     : word data (lane k at [k*PIX_W +: PIX_W]), per-lane write mask
//   frame_done               : pulses with the write holding pixel FRAME_PIX-1
//   err_noaddr               : sticky, a pixel arrived before any address beat
//   PIXEL_PACKER_STATS_EN    : adds words_written (32b) and pixels_dropped (16b, saturating)
module pixel_word_packer #(
    parameter int PIX_W     = 8,
    parameter int PACK      = 4,
    parameter int ADDR_W    = 24,
    parameter int FRAME_PIX = lightboard_pkg::FRAME_PIX
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            addr_axiiv,
    input  logic [ADDR_W-1:0]               addr_axiid,
    input  logic                            pixel_axiiv,
    input  logic [PIX_W-1:0]                pixel_axiid,
    input  logic                            flush,
    output logic                            axiov,
    output logic [ADDR_W-$clog2(PACK)-1:0]  addr_axiod,
    output logic [PIX_W*PACK-1:0]           pixel_axiod,
    output logic [PACK-1:0]                 lane_we,
    output logic                            frame_done,
    output logic                            err_noaddr
`ifdef PIXEL_PACKER_STATS_EN
    ,
    output logic [31:0]                     words_written,
    output logic [15:0]                     pixels_dropped
`endif
);

    import lightboard_pkg::*;

    localparam int LG   = $clog2(PACK);
    localparam int LW   = (PACK > 1) ? LG : 1;
    localparam int WA_W = ADDR_W - LG;

    lightboard_pkg::packer_state_t state;
    logic [ADDR_W-1:0]     idx, cur_idx;
    logic [LW-1:0]         lane;
    logic [WA_W-1:0]       cur_word, word_addr;
    logic                  accept, pix_last, lane_last;
    logic                  commit_old, commit_now, acc_clr, acc_load;
    logic                  hold, last_flag;
    logic [PIX_W*PACK-1:0] acc_data, ins_data;
    logic [PACK-1:0]       acc_mask, ins_mask;

    lane_accumulator #(.PIX_W(PIX_W), .PACK(PACK), .LW(LW)) u_acc (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (acc_clr),
        .load (acc_load),
        .lane (lane),
        .din  (pixel_axiid),
        .data (acc_data),
        .mask (acc_mask)
    );

    // commit_old writes the registered word as-is (new address beat, or a word
    // completed alongside such a beat and deferred one cycle via hold); the
    // same-cycle pixel then starts a fresh accumulator. commit_now writes the
    // registered word with the same-cycle pixel merged in.
    always_comb begin
        cur_idx    = addr_axiiv ? addr_axiid : idx;
        lane       = LW'(cur_idx % ADDR_W'(PACK));
        cur_word   = WA_W'(cur_idx >> LG);
        accept     = pixel_axiiv && (state == lightboard_pkg::PACK || addr_axiiv);
        pix_last   = cur_idx == ADDR_W'(FRAME_PIX - 1);
        lane_last  = lane == LW'(PACK - 1);
        commit_old = (|acc_mask) && (addr_axiiv || hold);
        ins_data   = acc_data;
        ins_mask   = acc_mask;
        if (accept) begin
            ins_data[lane*PIX_W +: PIX_W] = pixel_axiid;
            ins_mask[lane]                = 1'b1;
        end
        commit_now = !commit_old && (|ins_mask) && ((accept && (lane_last || pix_last)) || flush);
        acc_clr    = commit_old || commit_now;
        acc_load   = accept && !commit_now;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= lightboard_pkg::IDLE;
            idx         <= '0;
            word_addr   <= '0;
            hold        <= 1'b0;
            last_flag   <= 1'b0;
            axiov       <= 1'b0;
            addr_axiod  <= '0;
            pixel_axiod <= '0;
            lane_we     <= '0;
            frame_done  <= 1'b0;
            err_noaddr  <= 1'b0;
        end else begin
            if (addr_axiiv)
                state <= lightboard_pkg::PACK;
            if (accept)
                idx <= pix_last ? '0 : cur_idx + 1'b1;
            else if (addr_axiiv)
                idx <= addr_axiid;
            if (pixel_axiiv && !accept)
                err_noaddr <= 1'b1;
            hold <= commit_old && acc_load && (lane_last || pix_last || flush);
            if (acc_load)
                word_addr <= cur_word;
            if (acc_clr || acc_load)
                last_flag <= acc_load && pix_last;
            axiov      <= acc_clr;
            frame_done <= commit_old ? last_flag : (commit_now && accept && pix_last);
            if (acc_clr) begin
                addr_axiod  <= (commit_old || !accept) ? word_addr : cur_word;
                pixel_axiod <= commit_old ? acc_data : ins_data;
                lane_we     <= commit_old ? acc_mask : ins_mask;
            end
        end
    end

`ifdef PIXEL_PACKER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_written  <= '0;
            pixels_dropped <= '0;
        end else begin
            if (acc_clr)
                words_written <= words_written + 1'b1;
            if (pixel_axiiv && !accept && pixels_dropped != '1)
                pixels_dropped <= pixels_dropped + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_word_packer.sv
// tb_pixel_word_packer: directed scenarios plus randomized stream against a lane/array reference model
module tb_pixel_word_packer;

    localparam int PIX_W     = 8;
    localparam int PACK      = 4;
    localparam int ADDR_W    = 24;
    localparam int FRAME_PIX = 16;
    localparam int WA_W      = ADDR_W - 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              addr_axiiv = 1'b0;
    logic [ADDR_W-1:0] addr_axiid = '0;
    logic              pixel_axiiv = 1'b0;
    logic [PIX_W-1:0]  pixel_axiid = '0;
    logic              flush = 1'b0;
    logic              axiov;
    logic [WA_W-1:0]   addr_axiod;
    logic [31:0]       pixel_axiod;
    logic [PACK-1:0]   lane_we;
    logic              frame_done;
    logic              err_noaddr;
`ifdef PIXEL_PACKER_STATS_EN
    logic [31:0]       words_written;
    logic [15:0]       pixels_dropped;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    pixel_word_packer #(
        .PIX_W(PIX_W), .PACK(PACK), .ADDR_W(ADDR_W), .FRAME_PIX(FRAME_PIX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .addr_axiiv(addr_axiiv), .addr_axiid(addr_axiid),
        .pixel_axiiv(pixel_axiiv), .pixel_axiid(pixel_axiid),
        .flush(flush),
        .axiov(axiov), .addr_axiod(addr_axiod), .pixel_axiod(pixel_axiod),
        .lane_we(lane_we), .frame_done(frame_done), .err_noaddr(err_noaddr)
`ifdef PIXEL_PACKER_STATS_EN
        , .words_written(words_written), .pixels_dropped(pixels_dropped)
`endif
    );

    task automatic drive(input logic av, input logic [ADDR_W-1:0] a, input logic pv,
                         input logic [PIX_W-1:0] p, input logic f);
        addr_axiiv  = av;
        addr_axiid  = a;
        pixel_axiiv = pv;
        pixel_axiid = p;
        flush       = f;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] pack_word(input logic [7:0] l [PACK], input bit [PACK-1:0] m);
        logic [31:0] w = '0;
        for (int k = 0; k < PACK; k++)
            if (m[k]) w = w | (32'(l[k]) << (8 * k));
        return w;
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (axiov !== 1'b0) begin fails++; $display("FAIL reset_axiov: got %b want 0", axiov); end
        checks++; if (addr_axiod !== '0) begin fails++; $display("FAIL reset_addr: got %h want 0", addr_axiod); end
        checks++; if (pixel_axiod !== '0) begin fails++; $display("FAIL reset_data: got %h want 0", pixel_axiod); end
        checks++; if ({lane_we, frame_done, err_noaddr} !== '0) begin fails++; $display("FAIL reset_flags: got we=%b fd=%b err=%b want 0", lane_we, frame_done, err_noaddr); end
    endtask

    task automatic test_noaddr();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 8'h55, 0);
            checks++; if (axiov !== 1'b0) begin fails++; $display("FAIL noaddr_axiov: got %b want 0", axiov); end
            checks++; if (err_noaddr !== 1'b1) begin fails++; $display("FAIL noaddr_err: got %b want 1", err_noaddr); end
        end
`ifdef PIXEL_PACKER_STATS_EN
        checks++; if (pixels_dropped !== 16'd3) begin fails++; $display("FAIL stats_dropped: got %0d want 3", pixels_dropped); end
`endif
    endtask

    task automatic test_aligned();
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 8'h10 + 8'(i), 0);
            checks++; if (axiov !== 1'b0) begin fails++; $display("FAIL aligned_early: got %b want 0 at pixel %0d", axiov, i); end
        end
        drive(0, 0, 1, 8'h13, 0);
        checks++; if (axiov !== 1'b1) begin fails++; $display("FAIL aligned_axiov: got %b want 1", axiov); end
        checks++; if (addr_axiod !== 22'd0) begin fails++; $display("FAIL aligned_addr: got %h want 0", addr_axiod); end
        checks++; if (pixel_axiod !== 32'h13121110) begin fails++; $display("FAIL aligned_data: got %h want 13121110", pixel_axiod); end
        checks++; if (lane_we !== 4'hF) begin fails++; $display("FAIL aligned_we: got %b want 1111", lane_we); end
        drive(0, 0, 0, 0, 0);
        checks++; if (axiov !== 1'b0) begin fails++; $display("FAIL aligned_pulse: got %b want 0", axiov); end
`ifdef PIXEL_PACKER_STATS_EN
        checks++; if (words_written !== 32'd1) begin fails++; $display("FAIL stats_words: got %0d want 1", words_written); end
`endif
    endtask

    task automatic test_unaligned();
        drive(1, 6, 1, 8'hA0, 0);
        checks++; if (axiov !== 1'b0) begin fails++; $display("FAIL unal_early: got %b want 0", axiov); end
        drive(0, 0, 1, 8'hA1, 0);
        checks++; if ({axiov, addr_axiod} !== {1'b1, 22'd1}) begin fails++; $display("FAIL unal_addr: got v=%b a=%h want v=1 a=1", axiov, addr_axiod); end
        checks++; if (lane_we !== 4'b1100) begin fails++; $display("FAIL unal_we: got %b want 1100", lane_we); end
        checks++; if (pixel_axiod !== 32'hA1A00000) begin fails++; $display("FAIL unal_data: got %h want a1a00000", pixel_axiod); end
    endtask

    task automatic test_wrap();
        drive(1, 14, 0, 0, 0);
        drive(0, 0, 1, 8'hB0, 0);
        drive(0, 0, 1, 8'hB1, 0);
        checks++; if ({axiov, frame_done, addr_axiod, lane_we} !== {1'b1, 1'b1, 22'd3, 4'b1100}) begin fails++; $display("FAIL wrap_first: got v=%b fd=%b a=%h we=%b want v=1 fd=1 a=3 we=1100", axiov, frame_done, addr_axiod, lane_we); end
        checks++; if (pixel_axiod !== 32'hB1B00000) begin fails++; $display("FAIL wrap_first_data: got %h want b1b00000", pixel_axiod); end
        drive(0, 0, 1, 8'hB2, 0);
        checks++; if ({axiov, frame_done} !== 2'b00) begin fails++; $display("FAIL wrap_pulse: got v=%b fd=%b want 0 0", axiov, frame_done); end
        drive(0, 0, 1, 8'hB3, 0);
        drive(0, 0, 0, 0, 1);
        checks++; if ({axiov, frame_done, addr_axiod, lane_we} !== {1'b1, 1'b0, 22'd0, 4'b0011}) begin fails++; $display("FAIL wrap_flush: got v=%b fd=%b a=%h we=%b want v=1 fd=0 a=0 we=0011", axiov, frame_done, addr_axiod, lane_we); end
        checks++; if (pixel_axiod !== 32'h0000B3B2) begin fails++; $display("FAIL wrap_flush_data: got %h want 0000b3b2", pixel_axiod); end
        drive(0, 0, 0, 0, 1);
        checks++; if (axiov !== 1'b0) begin fails++; $display("FAIL flush_empty: got %b want 0", axiov); end
    endtask

    task automatic test_addr_switch();
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 1, 8'hC0, 0);
        drive(0, 0, 1, 8'hC1, 0);
        drive(1, 8, 1, 8'hD0, 0);
        checks++; if ({axiov, addr_axiod, lane_we} !== {1'b1, 22'd0, 4'b0011}) begin fails++; $display("FAIL switch_old: got v=%b a=%h we=%b want v=1 a=0 we=0011", axiov, addr_axiod, lane_we); end
        checks++; if (pixel_axiod !== 32'h0000C1C0) begin fails++; $display("FAIL switch_old_data: got %h want 0000c1c0", pixel_axiod); end
        drive(0, 0, 0, 0, 1);
        checks++; if ({axiov, addr_axiod, lane_we, pixel_axiod} !== {1'b1, 22'd2, 4'b0001, 32'h000000D0}) begin fails++; $display("FAIL switch_new: got v=%b a=%h we=%b d=%h want v=1 a=2 we=0001 d=000000d0", axiov, addr_axiod, lane_we, pixel_axiod); end
        checks++; if (err_noaddr !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", err_noaddr); end
    endtask

    task automatic test_reset_mid_word();
        drive(1, 0, 1, 8'hE0, 0);
        drive(0, 0, 1, 8'hE1, 0);
        rst_n = 1'b0;
        #1;
        checks++; if ({axiov, addr_axiod, pixel_axiod, lane_we, frame_done, err_noaddr} !== '0) begin fails++; $display("FAIL midreset_outputs: got v=%b a=%h d=%h we=%b fd=%b err=%b want all 0", axiov, addr_axiod, pixel_axiod, lane_we, frame_done, err_noaddr); end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0);
            checks++; if (axiov !== 1'b0) begin fails++; $display("FAIL midreset_write: got %b want 0", axiov); end
        end
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 1);
        checks++; if (axiov !== 1'b0) begin fails++; $display("FAIL midreset_flush: got %b want 0", axiov); end
        drive(1, 2, 1, 8'hF2, 0);
        drive(0, 0, 1, 8'hF3, 0);
        checks++; if ({axiov, lane_we, pixel_axiod} !== {1'b1, 4'b1100, 32'hF3F20000}) begin fails++; $display("FAIL midreset_clean: got v=%b we=%b d=%h want v=1 we=1100 d=f3f20000", axiov, lane_we, pixel_axiod); end
    endtask

    task automatic test_random();
        int m_idx = 0, m_word = 0, k;
        bit m_run = 0, m_err = 0;
        logic [7:0] m_lane [PACK];
        bit [PACK-1:0] m_mask = '0;
        bit ev, efd, av, pv, f;
        int ewa;
        logic [31:0] ed;
        bit [PACK-1:0] em;
        logic [ADDR_W-1:0] a;
        logic [7:0] p;
        for (int j = 0; j < PACK; j++) m_lane[j] = '0;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            av = ($urandom % 8) == 0;
            pv = ($urandom % 4) != 0;
            f  = !av && (($urandom % 10) == 0);
            p  = 8'($urandom);
            a  = pv ? ADDR_W'(($urandom % (FRAME_PIX / PACK)) * PACK + $urandom % (PACK - 1))
                    : ADDR_W'($urandom % FRAME_PIX);
            ev = 0; efd = 0; ewa = 0; ed = '0; em = '0;
            if (av) begin
                if (m_mask != 0) begin
                    ev = 1; ewa = m_word; em = m_mask; ed = pack_word(m_lane, m_mask); m_mask = '0;
                end
                m_idx = int'(a);
                m_run = 1;
            end
            if (pv && !m_run) m_err = 1;
            if (pv && m_run) begin
                k = m_idx % PACK;
                m_lane[k] = p;
                m_mask[k] = 1;
                m_word = m_idx / PACK;
                if (k == PACK - 1 || m_idx == FRAME_PIX - 1) begin
                    ev = 1; ewa = m_word; em = m_mask; ed = pack_word(m_lane, m_mask);
                    efd = m_idx == FRAME_PIX - 1; m_mask = '0;
                end
                m_idx = (m_idx + 1) % FRAME_PIX;
            end
            if (f && m_mask != 0) begin
                ev = 1; ewa = m_word; em = m_mask; ed = pack_word(m_lane, m_mask); m_mask = '0;
            end
            drive(av, a, pv, p, f);
            checks++; if (axiov !== ev) begin fails++; $display("FAIL rand_axiov[%0d]: got %b want %b", n, axiov, ev); end
            checks++; if (frame_done !== efd) begin fails++; $display("FAIL rand_fd[%0d]: got %b want %b", n, frame_done, efd); end
            checks++; if (err_noaddr !== m_err) begin fails++; $display("FAIL rand_err[%0d]: got %b want %b", n, err_noaddr, m_err); end
            if (ev) begin
                checks++; if ({addr_axiod, lane_we, pixel_axiod} !== {WA_W'(ewa), em, ed}) begin fails++; $display("FAIL rand_word[%0d]: got a=%h we=%b d=%h want a=%h we=%b d=%h", n, addr_axiod, lane_we, pixel_axiod, ewa, em, ed); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_noaddr();
        test_aligned();
        test_unaligned();
        test_wrap();
        test_addr_switch();
        test_reset_mid_word();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
